// File: rtl/network_interface_pkg.sv
// pa_noc: shared packet layout, FSM encodings and small helpers for the
// APB-over-mesh network interface.
package pa_noc;

    localparam int APB_ADDR_W       = 32;
    localparam int APB_DATA_W       = 32;
    localparam int NI_COORD_W       = 4;
    localparam int APB_PACKET_WIDTH = 4 + 4 * NI_COORD_W + APB_ADDR_W + APB_DATA_W;

    typedef struct packed {
        logic                  valid;
        logic                  resp;
        logic                  write;
        logic                  err;
        logic [NI_COORD_W-1:0] srcRow;
        logic [NI_COORD_W-1:0] srcCol;
        logic [NI_COORD_W-1:0] dstRow;
        logic [NI_COORD_W-1:0] dstCol;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] data;
    } apbPacket_t;

    typedef enum logic [1:0] {I_IDLE, I_SEND, I_WAIT, I_DONE} initState_t;
    typedef enum logic [1:0] {T_IDLE, T_SETUP, T_ACCESS, T_RESP} tgtState_t;

    function automatic logic isForNode(input apbPacket_t pkt,
                                       input logic [NI_COORD_W-1:0] row,
                                       input logic [NI_COORD_W-1:0] col);
        return pkt.valid && (pkt.dstRow == row) && (pkt.dstCol == col);
    endfunction

endpackage

// File: rtl/network_interface_apb_requester.sv
// ni_apb_requester: replays request packets from the router on the local APB
// requester port and builds the matching response packet.
module ni_apb_requester
    import pa_noc::*;
#(
    parameter logic [NI_COORD_W-1:0] SELF_ROW = '0,
    parameter logic [NI_COORD_W-1:0] SELF_COL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  apbPacket_t            i_pkt,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [APB_ADDR_W-1:0] o_paddr,
    output logic [APB_DATA_W-1:0] o_pwdata,
    input  logic [APB_DATA_W-1:0] i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr,
    output apbPacket_t            o_respPkt,
    output logic                  o_respValid,
    input  logic                  i_respGrant,
    output logic                  o_overflow
);

    tgtState_t             state_r;
    logic                  holdValid_r;
    logic [NI_COORD_W-1:0] holdSrcRow_r;
    logic [NI_COORD_W-1:0] holdSrcCol_r;
    logic [APB_ADDR_W-1:0] holdAddr_r;
    logic                  holdWrite_r;
    apbPacket_t            resp_r;
    apbPacket_t            built_s;
    logic                  capture_s;
    logic                  accept_s;
    logic                  unusedErr_s;

    assign unusedErr_s = i_pkt.err;
    assign capture_s   = isForNode(i_pkt, SELF_ROW, SELF_COL) && !i_pkt.resp;
    assign accept_s    = capture_s && !holdValid_r && (state_r == T_IDLE);
    assign o_respValid = (state_r == T_RESP) || ((state_r == T_ACCESS) && i_pready);

    // Response built live from the completing access so it can leave on the same edge.
    always_comb begin
        built_s        = '0;
        built_s.valid  = 1'b1;
        built_s.resp   = 1'b1;
        built_s.write  = holdWrite_r;
        built_s.err    = i_pslverr;
        built_s.srcRow = SELF_ROW;
        built_s.srcCol = SELF_COL;
        built_s.dstRow = holdSrcRow_r;
        built_s.dstCol = holdSrcCol_r;
        built_s.addr   = holdAddr_r;
        if (holdWrite_r) begin
            built_s.data = {APB_DATA_W{1'b0}};
        end else begin
            built_s.data = i_prdata;
        end
        if (state_r == T_RESP) begin
            o_respPkt = resp_r;
        end else begin
            o_respPkt = built_s;
        end
    end

    // Target FSM, holding register, APB requester outputs and overflow flag.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r      <= T_IDLE;
            holdValid_r  <= 1'b0;
            holdSrcRow_r <= '0;
            holdSrcCol_r <= '0;
            holdAddr_r   <= '0;
            holdWrite_r  <= 1'b0;
            resp_r       <= '0;
            o_psel       <= 1'b0;
            o_penable    <= 1'b0;
            o_pwrite     <= 1'b0;
            o_paddr      <= '0;
            o_pwdata     <= '0;
            o_overflow   <= 1'b0;
        end else begin
            if (capture_s && !accept_s) begin
                o_overflow <= 1'b1;
            end
            case (state_r)
                T_IDLE: begin
                    if (accept_s) begin
                        holdValid_r  <= 1'b1;
                        holdSrcRow_r <= i_pkt.srcRow;
                        holdSrcCol_r <= i_pkt.srcCol;
                        holdAddr_r   <= i_pkt.addr;
                        holdWrite_r  <= i_pkt.write;
                        o_psel       <= 1'b1;
                        o_penable    <= 1'b0;
                        o_pwrite     <= i_pkt.write;
                        o_paddr      <= i_pkt.addr;
                        o_pwdata     <= i_pkt.data;
                        state_r      <= T_SETUP;
                    end
                end
                T_SETUP: begin
                    o_penable <= 1'b1;
                    state_r   <= T_ACCESS;
                end
                T_ACCESS: begin
                    if (i_pready) begin
                        o_psel    <= 1'b0;
                        o_penable <= 1'b0;
                        o_pwrite  <= 1'b0;
                        o_paddr   <= '0;
                        o_pwdata  <= '0;
                        resp_r    <= built_s;
                        if (i_respGrant) begin
                            holdValid_r <= 1'b0;
                            state_r     <= T_IDLE;
                        end else begin
                            state_r <= T_RESP;
                        end
                    end
                end
                T_RESP: begin
                    if (i_respGrant) begin
                        holdValid_r <= 1'b0;
                        state_r     <= T_IDLE;
                    end
                end
                default: begin
                    state_r <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/network_interface.sv
// network_interface: bridges a local APB node onto its mesh router port.
// Define NI_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module network_interface
    import pa_noc::*;
#(
    parameter int GRID_WIDTH     = 4,
    parameter int NI_ROW         = 0,
    parameter int NI_COL         = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic                        i_psel,
    input  logic                        i_penable,
    input  logic                        i_pwrite,
    input  logic [APB_ADDR_W-1:0]       i_paddr,
    input  logic [APB_DATA_W-1:0]       i_pwdata,
    output logic [APB_DATA_W-1:0]       o_prdata,
    output logic                        o_pready,
    output logic                        o_pslverr,
    output logic                        o_psel,
    output logic                        o_penable,
    output logic                        o_pwrite,
    output logic [APB_ADDR_W-1:0]       o_paddr,
    output logic [APB_DATA_W-1:0]       o_pwdata,
    input  logic [APB_DATA_W-1:0]       i_prdata,
    input  logic                        i_pready,
    input  logic                        i_pslverr,
    output logic [APB_PACKET_WIDTH-1:0] o_niToRouter,
    input  logic [APB_PACKET_WIDTH-1:0] i_routerToNi,
    output logic                        o_overflow
);

    localparam int                    LIM_W    = NI_COORD_W + 1;
    localparam logic [NI_COORD_W-1:0] SELF_ROW = NI_COORD_W'(NI_ROW);
    localparam logic [NI_COORD_W-1:0] SELF_COL = NI_COORD_W'(NI_COL);
    localparam logic [LIM_W-1:0]      GRID_LIM = LIM_W'(GRID_WIDTH);

    initState_t            state_r;
    apbPacket_t            inPkt_s;
    apbPacket_t            reqPkt_s;
    apbPacket_t            respPkt_s;
    apbPacket_t            outPkt_r;
    logic [NI_COORD_W-1:0] dstRowIn_s;
    logic [NI_COORD_W-1:0] dstColIn_s;
    logic [NI_COORD_W-1:0] dstRow_r;
    logic [NI_COORD_W-1:0] dstCol_r;
    logic [APB_ADDR_W-1:0] addr_r;
    logic [APB_DATA_W-1:0] wdata_r;
    logic                  write_r;
    logic                  access_s;
    logic                  dstBad_s;
    logic                  reqValid_s;
    logic                  respValid_s;
    logic                  respMatch_s;
    logic                  timeout_s;

    assign inPkt_s      = i_routerToNi;
    assign o_niToRouter = outPkt_r;
    assign access_s     = i_psel && i_penable;
    assign dstRowIn_s   = i_paddr[31:28];
    assign dstColIn_s   = i_paddr[27:24];
    assign dstBad_s     = ({1'b0, dstRowIn_s} >= GRID_LIM) || ({1'b0, dstColIn_s} >= GRID_LIM)
                       || ((dstRowIn_s == SELF_ROW) && (dstColIn_s == SELF_COL));
    assign reqValid_s   = (state_r == I_SEND) || ((state_r == I_IDLE) && access_s && !dstBad_s);
    assign respMatch_s  = isForNode(inPkt_s, SELF_ROW, SELF_COL) && inPkt_s.resp
                       && (inPkt_s.srcRow == dstRow_r) && (inPkt_s.srcCol == dstCol_r);

`ifdef NI_TIMEOUT_EN
    logic [31:0] waitCnt_r;

    // WAIT-state age; held at zero outside WAIT so every entry starts fresh.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            waitCnt_r <= 32'd0;
        end else if (state_r == I_WAIT) begin
            waitCnt_r <= waitCnt_r + 32'd1;
        end else begin
            waitCnt_r <= 32'd0;
        end
    end

    assign timeout_s = (state_r == I_WAIT) && (waitCnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign timeout_s = 1'b0;
`endif

    // An IDLE request is taken straight from the bus so an uncontended one leaves next cycle.
    always_comb begin
        reqPkt_s        = '0;
        reqPkt_s.valid  = 1'b1;
        reqPkt_s.srcRow = SELF_ROW;
        reqPkt_s.srcCol = SELF_COL;
        if (state_r == I_SEND) begin
            reqPkt_s.write  = write_r;
            reqPkt_s.dstRow = dstRow_r;
            reqPkt_s.dstCol = dstCol_r;
            reqPkt_s.addr   = addr_r;
            reqPkt_s.data   = write_r ? wdata_r : {APB_DATA_W{1'b0}};
        end else begin
            reqPkt_s.write  = i_pwrite;
            reqPkt_s.dstRow = dstRowIn_s;
            reqPkt_s.dstCol = dstColIn_s;
            reqPkt_s.addr   = i_paddr;
            reqPkt_s.data   = i_pwrite ? i_pwdata : {APB_DATA_W{1'b0}};
        end
    end

    ni_apb_requester #(
        .SELF_ROW (SELF_ROW),
        .SELF_COL (SELF_COL)
    ) uRequester (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_pkt       (inPkt_s),
        .o_psel      (o_psel),
        .o_penable   (o_penable),
        .o_pwrite    (o_pwrite),
        .o_paddr     (o_paddr),
        .o_pwdata    (o_pwdata),
        .i_prdata    (i_prdata),
        .i_pready    (i_pready),
        .i_pslverr   (i_pslverr),
        .o_respPkt   (respPkt_s),
        .o_respValid (respValid_s),
        .i_respGrant (respValid_s),
        .o_overflow  (o_overflow)
    );

    // Injection register: responses win, requests otherwise, idle packet is all zero.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            outPkt_r <= '0;
        end else if (respValid_s) begin
            outPkt_r <= respPkt_s;
        end else if (reqValid_s) begin
            outPkt_r <= reqPkt_s;
        end else begin
            outPkt_r <= '0;
        end
    end

    // Initiator FSM with registered APB completer outputs.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r   <= I_IDLE;
            dstRow_r  <= '0;
            dstCol_r  <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            write_r   <= 1'b0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
        end else begin
            case (state_r)
                I_IDLE: begin
                    if (access_s) begin
                        dstRow_r <= dstRowIn_s;
                        dstCol_r <= dstColIn_s;
                        addr_r   <= i_paddr;
                        wdata_r  <= i_pwdata;
                        write_r  <= i_pwrite;
                        if (dstBad_s) begin
                            o_pready  <= 1'b1;
                            o_pslverr <= 1'b1;
                            o_prdata  <= '0;
                            state_r   <= I_DONE;
                        end else if (respValid_s) begin
                            state_r <= I_SEND;
                        end else begin
                            state_r <= I_WAIT;
                        end
                    end
                end
                I_SEND: begin
                    if (!respValid_s) begin
                        state_r <= I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (respMatch_s) begin
                        o_pready  <= 1'b1;
                        o_pslverr <= inPkt_s.err;
                        o_prdata  <= inPkt_s.data;
                        state_r   <= I_DONE;
                    end else if (timeout_s) begin
                        o_pready  <= 1'b1;
                        o_pslverr <= 1'b1;
                        o_prdata  <= '0;
                        state_r   <= I_DONE;
                    end
                end
                I_DONE: begin
                    o_pready  <= 1'b0;
                    o_pslverr <= 1'b0;
                    o_prdata  <= '0;
                    state_r   <= I_IDLE;
                end
                default: begin
                    state_r <= I_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_interface.sv
// Self-checking bench for network_interface at node (0,0) of a 4x4 mesh;
// the timeout scenario is compiled only when NI_TIMEOUT_EN is defined.
module tb_network_interface;
    import pa_noc::*;

    localparam int GW = 4;
    localparam int TO = 8;

    logic                        clk = 1'b0;
    logic                        arstN = 1'b0;
    logic                        psel, penable, pwrite;
    logic [31:0]                 paddr, pwdata, prdata;
    logic                        pready, pslverr;
    logic                        reqPsel, reqPenable, reqPwrite;
    logic [31:0]                 reqPaddr, reqPwdata, reqPrdata;
    logic                        reqPready, reqPslverr;
    logic [APB_PACKET_WIDTH-1:0] niToRouter, routerToNi;
    logic                        overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    network_interface #(
        .GRID_WIDTH(GW), .NI_ROW(0), .NI_COL(0), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_arst_n(arstN),
        .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata),
        .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
        .o_psel(reqPsel), .o_penable(reqPenable), .o_pwrite(reqPwrite),
        .o_paddr(reqPaddr), .o_pwdata(reqPwdata),
        .i_prdata(reqPrdata), .i_pready(reqPready), .i_pslverr(reqPslverr),
        .o_niToRouter(niToRouter), .i_routerToNi(routerToNi),
        .o_overflow(overflow)
    );

    // Reference packet builder straight from the documented field order.
    function automatic logic [83:0] mkPkt(input logic v, input logic r, input logic w, input logic e,
                                          input logic [3:0] sr, input logic [3:0] sc,
                                          input logic [3:0] dr, input logic [3:0] dc,
                                          input logic [31:0] a, input logic [31:0] d);
        return {v, r, w, e, sr, sc, dr, dc, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        reqPrdata = 32'd0; reqPready = 1'b0; reqPslverr = 1'b0; routerToNi = '0;
    endtask

    task automatic pickRemote(output logic [3:0] r, output logic [3:0] c);
        r = 4'd0; c = 4'd0;
        while (r == 4'd0 && c == 4'd0) begin
            r = 4'($urandom_range(0, GW - 1));
            c = 4'($urandom_range(0, GW - 1));
        end
    endtask

    // Setup then access phase; returns just after the edge that samples the access phase.
    task automatic localAccess(input logic [31:0] a, input logic [31:0] d, input logic w);
        psel = 1'b1; penable = 1'b0; paddr = a; pwdata = d; pwrite = w;
        tick();
        penable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        arstN = 1'b0;
        quiet();
        tick();
        checks++;
        if (niToRouter !== '0) begin failures++; $display("FAIL reset_pkt: got %h want 0", niToRouter); end
        checks++;
        if ({pready, pslverr, prdata} !== 34'd0) begin
            failures++; $display("FAIL reset_completer: got %h want 0", {pready, pslverr, prdata});
        end
        checks++;
        if ({reqPsel, reqPenable, reqPwrite, reqPaddr, reqPwdata} !== 67'd0) begin
            failures++; $display("FAIL reset_requester: got %h want 0", {reqPsel, reqPenable, reqPwrite, reqPaddr, reqPwdata});
        end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        arstN = 1'b1;
        tick();
    endtask

    task automatic test_remote_access();
        logic [3:0] r, c;
        logic [31:0] a, d, rd;
        logic w, e;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                r = 4'd1; c = 4'd1; a = 32'h1100_0040; d = 32'd0; w = 1'b0; rd = 32'hDEAD_BEEF; e = 1'b0;
            end else begin
                pickRemote(r, c);
                a = {r, c, 24'($urandom)}; d = $urandom; w = 1'($urandom); rd = $urandom; e = 1'($urandom);
            end
            localAccess(a, d, w);
            checks++;
            if (niToRouter !== mkPkt(1'b1, 1'b0, w, 1'b0, 4'd0, 4'd0, r, c, a, w ? d : 32'd0)) begin
                failures++; $display("FAIL req_pkt[%0d]: got %h want %h", i, niToRouter,
                                     mkPkt(1'b1, 1'b0, w, 1'b0, 4'd0, 4'd0, r, c, a, w ? d : 32'd0));
            end
            tick();
            checks++;
            if (niToRouter[83] !== 1'b0 || pready !== 1'b0) begin
                failures++; $display("FAIL req_oneshot[%0d]: got valid=%b pready=%b want 0 0", i, niToRouter[83], pready);
            end
            // Response from the wrong source must be ignored.
            routerToNi = mkPkt(1'b1, 1'b1, w, 1'b0, r, c ^ 4'd1, 4'd0, 4'd0, a, $urandom);
            tick();
            routerToNi = '0;
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (pready !== 1'b0) begin failures++; $display("FAIL stray_resp[%0d]: got pready=%b want 0", i, pready); end
            routerToNi = mkPkt(1'b1, 1'b1, w, e, r, c, 4'd0, 4'd0, a, rd);
            tick();
            routerToNi = '0;
            checks++;
            if ({pready, pslverr, prdata} !== {1'b1, e, rd}) begin
                failures++; $display("FAIL resp_done[%0d]: got %h want %h", i, {pready, pslverr, prdata}, {1'b1, e, rd});
            end
            psel = 1'b0; penable = 1'b0;
            tick();
            checks++;
            if (pready !== 1'b0) begin failures++; $display("FAIL done_oneshot[%0d]: got %b want 0", i, pready); end
        end
    endtask

    task automatic test_local_error();
        logic [31:0] addrs [4];
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h5000_0000;
        addrs[2] = {4'd1, 4'($urandom_range(4, 15)), 24'($urandom)};
        addrs[3] = {4'($urandom_range(4, 15)), 4'($urandom_range(0, 15)), 24'($urandom)};
        for (int i = 0; i < 4; i++) begin
            localAccess(addrs[i], $urandom, 1'b1);
            checks++;
            if ({pready, pslverr, prdata, niToRouter[83]} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
                failures++; $display("FAIL bad_dst[%0d]: got pready=%b err=%b rdata=%h pktvalid=%b want 1 1 0 0",
                                     i, pready, pslverr, prdata, niToRouter[83]);
            end
            psel = 1'b0; penable = 1'b0;
            tick();
            checks++;
            if (pready !== 1'b0 || niToRouter[83] !== 1'b0) begin
                failures++; $display("FAIL bad_dst_after[%0d]: got pready=%b pktvalid=%b want 0 0", i, pready, niToRouter[83]);
            end
        end
    endtask

    task automatic test_remote_target();
        logic [3:0] sr, sc;
        logic [31:0] a, d, rd;
        logic w, e;
        int waits;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                sr = 4'd2; sc = 4'd3; a = 32'h0000_0010; d = $urandom; w = 1'b1; e = 1'b0; rd = $urandom; waits = 2;
            end else begin
                pickRemote(sr, sc);
                a = $urandom; d = $urandom; w = 1'($urandom); e = 1'($urandom); rd = $urandom;
                waits = $urandom_range(0, 3);
            end
            routerToNi = mkPkt(1'b1, 1'b0, w, 1'b0, sr, sc, 4'd0, 4'd0, a, d);
            tick();
            routerToNi = '0;
            checks++;
            if ({reqPsel, reqPenable, reqPwrite, reqPaddr, reqPwdata} !== {1'b1, 1'b0, w, a, d}) begin
                failures++; $display("FAIL tgt_setup[%0d]: got %h want %h", i,
                                     {reqPsel, reqPenable, reqPwrite, reqPaddr, reqPwdata}, {1'b1, 1'b0, w, a, d});
            end
            tick();
            checks++;
            if ({reqPsel, reqPenable} !== 2'b11) begin
                failures++; $display("FAIL tgt_access[%0d]: got %b want 11", i, {reqPsel, reqPenable});
            end
            for (int k = 0; k < waits; k++) begin
                tick();
                checks++;
                if (reqPenable !== 1'b1 || niToRouter[83] !== 1'b0) begin
                    failures++; $display("FAIL tgt_wait[%0d]: got penable=%b pktvalid=%b want 1 0", i, reqPenable, niToRouter[83]);
                end
            end
            reqPready = 1'b1; reqPrdata = rd; reqPslverr = e;
            tick();
            reqPready = 1'b0; reqPslverr = 1'b0;
            checks++;
            if (niToRouter !== mkPkt(1'b1, 1'b1, w, e, 4'd0, 4'd0, sr, sc, a, w ? 32'd0 : rd)) begin
                failures++; $display("FAIL tgt_resp[%0d]: got %h want %h", i, niToRouter,
                                     mkPkt(1'b1, 1'b1, w, e, 4'd0, 4'd0, sr, sc, a, w ? 32'd0 : rd));
            end
            checks++;
            if ({reqPsel, reqPenable} !== 2'b00) begin
                failures++; $display("FAIL tgt_release[%0d]: got %b want 00", i, {reqPsel, reqPenable});
            end
            tick();
            checks++;
            if (niToRouter !== '0) begin failures++; $display("FAIL tgt_oneshot[%0d]: got %h want 0", i, niToRouter); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] aA, aC;
        aA = $urandom; aC = $urandom;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        routerToNi = mkPkt(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 4'd0, 4'd0, aA, 32'd0);
        tick();
        routerToNi = mkPkt(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, $urandom, $urandom);
        tick();
        routerToNi = '0;
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", overflow); end
        reqPready = 1'b1; reqPrdata = 32'h1234_5678;
        tick();
        reqPready = 1'b0;
        checks++;
        if (niToRouter !== mkPkt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 4'd3, aA, 32'h1234_5678)) begin
            failures++; $display("FAIL ovf_first_kept: got %h want %h", niToRouter,
                                 mkPkt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 4'd3, aA, 32'h1234_5678));
        end
        routerToNi = mkPkt(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 4'd0, aC, 32'd0);
        tick();
        routerToNi = '0;
        checks++;
        if ({overflow, reqPsel, reqPaddr} !== {1'b1, 1'b1, aC}) begin
            failures++; $display("FAIL ovf_sticky: got %h want %h", {overflow, reqPsel, reqPaddr}, {1'b1, 1'b1, aC});
        end
        tick();
        reqPready = 1'b1;
        tick();
        reqPready = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] la, rd, rd2;
        la = {4'd3, 4'd1, 24'($urandom)}; rd = $urandom; rd2 = $urandom;
        routerToNi = mkPkt(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 32'h0000_0080, 32'd0);
        tick();
        routerToNi = '0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = la; pwdata = 32'd0;
        tick();
        penable = 1'b1; reqPready = 1'b1; reqPrdata = rd;
        tick();
        reqPready = 1'b0;
        checks++;
        if (niToRouter !== mkPkt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 32'h0000_0080, rd)) begin
            failures++; $display("FAIL arb_resp_first: got %h want %h", niToRouter,
                                 mkPkt(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 32'h0000_0080, rd));
        end
        tick();
        checks++;
        if (niToRouter !== mkPkt(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 4'd1, la, 32'd0)) begin
            failures++; $display("FAIL arb_req_second: got %h want %h", niToRouter,
                                 mkPkt(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 4'd1, la, 32'd0));
        end
        tick();
        routerToNi = mkPkt(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 4'd0, 4'd0, la, rd2);
        tick();
        routerToNi = '0;
        checks++;
        if ({pready, prdata} !== {1'b1, rd2}) begin
            failures++; $display("FAIL arb_complete: got %h want %h", {pready, prdata}, {1'b1, rd2});
        end
        psel = 1'b0; penable = 1'b0;
        tick();
    endtask

`ifdef NI_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] a;
        a = {4'd2, 4'd2, 24'($urandom)};
        localAccess(a, 32'd0, 1'b0);
        for (int k = 1; k < TO; k++) begin
            tick();
            checks++;
            if (pready !== 1'b0) begin failures++; $display("FAIL to_early[%0d]: got pready=%b want 0", k, pready); end
        end
        tick();
        checks++;
        if ({pready, pslverr, prdata} !== {1'b1, 1'b1, 32'd0}) begin
            failures++; $display("FAIL to_fire: got %h want %h", {pready, pslverr, prdata}, {1'b1, 1'b1, 32'd0});
        end
        psel = 1'b0; penable = 1'b0;
        tick();
        routerToNi = mkPkt(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 4'd0, 4'd0, a, $urandom);
        tick();
        routerToNi = '0;
        tick();
        checks++;
        if (pready !== 1'b0) begin failures++; $display("FAIL to_late: got pready=%b want 0", pready); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] a;
        a = {4'd2, 4'd2, 24'($urandom)};
        localAccess(a, 32'd0, 1'b0);
        tick();
        #2;
        arstN = 1'b0;
        #1;
        checks++;
        if ({niToRouter, pready} !== 85'd0) begin
            failures++; $display("FAIL midrst_outputs: got %h want 0", {niToRouter, pready});
        end
        quiet();
        tick();
        arstN = 1'b1;
        routerToNi = mkPkt(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 4'd0, 4'd0, a, $urandom);
        tick();
        routerToNi = '0;
        tick();
        checks++;
        if ({pready, reqPsel, niToRouter[83]} !== 3'b000) begin
            failures++; $display("FAIL midrst_late: got %b want 000", {pready, reqPsel, niToRouter[83]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        test_reset();
        test_remote_access();
        test_local_error();
        test_remote_target();
        test_overflow();
        test_contention();
`ifdef NI_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
